// File: rtl/operand_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_entry_pkg
// Purpose  : Shared defaults for the operand-entry block and its interface.
// Contents : DEFAULT_INPUT_WIDTH     - operand width fed to the adder
//            DEFAULT_DEBOUNCE_CYCLES - 10 ms of stable level at 27 MHz
// Revision : 1.0 - initial release
// ============================================================================
package operand_entry_pkg;

    localparam int DEFAULT_INPUT_WIDTH     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;

endpackage : operand_entry_pkg
`default_nettype wire

// File: rtl/operand_entry_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_entry_if
// Purpose  : Bundles the raw button inputs and the operand outputs.
// Signals  : btn_a_n, btn_b_n - raw active-low push buttons (async, bouncy)
//            a, b             - registered operands to the adder
//            updated          - one-cycle strobe with every new a/b value
// Modports : master - button source / operand consumer
//            slave  - operand_entry
// Revision : 1.0 - initial release
// ============================================================================
interface operand_entry_if
    import operand_entry_pkg::*;
#(
    parameter int INPUT_WIDTH = DEFAULT_INPUT_WIDTH
) ();

    logic                   btn_a_n;
    logic                   btn_b_n;
    logic [INPUT_WIDTH-1:0] a;
    logic [INPUT_WIDTH-1:0] b;
    logic                   updated;

    modport master (
        output btn_a_n,
        output btn_b_n,
        input  a,
        input  b,
        input  updated
    );

    modport slave (
        input  btn_a_n,
        input  btn_b_n,
        output a,
        output b,
        output updated
    );

endinterface : operand_entry_if
`default_nettype wire

// File: rtl/operand_entry_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Synchronises one raw active-low button, debounces it and emits
//            a single-cycle pulse when the debounced level becomes pressed.
// Ports    : clk       - system clock
//            rst       - asynchronous active-high reset
//            btn_n_i   - raw active-low button (asynchronous, may bounce)
//            press_o   - registered one-cycle press event
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic btn_n_i,
    output logic      press_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Levels are kept in raw polarity: 1 = released, 0 = pressed.
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Any cycle the synchronised level agrees with the stable level restarts
    // the count, so only an uninterrupted run of differing samples flips it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                // Only the released->pressed direction is an event.
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule : button_debounce
`default_nettype wire

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : operand_entry
// Purpose  : Two push buttons step two adder operands. A press on A alone
//            increments a, on B alone increments b (both wrap silently);
//            presses on both in the same cycle clear a and b.
// Ports    : clk       - system clock
//            rst       - asynchronous active-high reset
//            bus       - operand_entry_if.slave (btn_a_n, btn_b_n in;
//                        a, b, updated out)
// Revision : 1.0 - initial release
// ============================================================================
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int INPUT_WIDTH     = DEFAULT_INPUT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  wire logic        clk,
    input  wire logic        rst,
    operand_entry_if.slave   bus
);

    logic                   press_a;
    logic                   press_b;
    logic [INPUT_WIDTH-1:0] a_q;
    logic [INPUT_WIDTH-1:0] a_d;
    logic [INPUT_WIDTH-1:0] b_q;
    logic [INPUT_WIDTH-1:0] b_d;
    logic                   updated_q;
    logic                   updated_d;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_a (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (bus.btn_a_n),
        .press_o (press_a)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_b (
        .clk     (clk),
        .rst     (rst),
        .btn_n_i (bus.btn_b_n),
        .press_o (press_b)
    );

    // A simultaneous press is a clear, and still strobes updated even when
    // both operands are already zero.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        updated_d = 1'b0;
        if (press_a && press_b) begin
            a_d       = '0;
            b_d       = '0;
            updated_d = 1'b1;
        end else if (press_a) begin
            a_d       = a_q + INPUT_WIDTH'(1);
            updated_d = 1'b1;
        end else if (press_b) begin
            b_d       = b_q + INPUT_WIDTH'(1);
            updated_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            updated_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            updated_q <= updated_d;
        end
    end

    assign bus.a       = a_q;
    assign bus.b       = b_q;
    assign bus.updated = updated_q;

endmodule : operand_entry
`default_nettype wire

// File: tb/tb_operand_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_entry
// Purpose  : Self-checking bench for operand_entry (INPUT_WIDTH=2,
//            DEBOUNCE_CYCLES=4) with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_entry;

    localparam int W = 2;
    localparam int D = 4;
    // Input driven just after edge k -> new operand visible after edge k+D+3.
    localparam int LAT = D + 3;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t         exp_q[$];
    logic [W-1:0] a_m = '0;
    logic [W-1:0] b_m = '0;

    operand_entry_if #(.INPUT_WIDTH(W)) bus ();

    operand_entry #(
        .INPUT_WIDTH     (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: reset state, expected updates, and silent operand changes.
    initial begin : monitor
        exp_t         e;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        pa = '0;
        pb = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (bus.a !== '0 || bus.b !== '0 || bus.updated !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: got a=%0d b=%0d updated=%b, required a=0 b=0 updated=0",
                             bus.a, bus.b, bus.updated);
                end
            end else if (bus.updated === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: cycle %0d a=%0d b=%0d, required no update",
                             cyc, bus.a, bus.b);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.a !== e.a || bus.b !== e.b || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL update: got a=%0d b=%0d at cycle %0d, required a=%0d b=%0d at cycle %0d",
                                 bus.a, bus.b, cyc, e.a, e.b, e.cyc);
                    end
                end
            end else if (bus.a !== pa || bus.b !== pb) begin
                checks++;
                errors++;
                $display("FAIL silent_change: cycle %0d got a=%0d b=%0d, required a=%0d b=%0d (no updated)",
                         cyc, bus.a, bus.b, pa, pb);
            end
            pa = bus.a;
            pb = bus.b;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press A and/or B cleanly, hold, release, let release settle.
    task automatic press(input logic pa, input logic pb, input int hold);
        exp_t e;
        if (pa && pb) begin
            a_m = '0;
            b_m = '0;
        end else if (pa) begin
            a_m = a_m + W'(1);
        end else begin
            b_m = b_m + W'(1);
        end
        e.a   = a_m;
        e.b   = b_m;
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
        if (pa) bus.btn_a_n = 1'b0;
        if (pb) bus.btn_b_n = 1'b0;
        step(hold);
        bus.btn_a_n = 1'b1;
        bus.btn_b_n = 1'b1;
        step(12);
    endtask

    task automatic check_ops(input string name);
        checks++;
        if (bus.a !== a_m || bus.b !== b_m) begin
            errors++;
            $display("FAIL %s: got a=%0d b=%0d, required a=%0d b=%0d",
                     name, bus.a, bus.b, a_m, b_m);
        end
    endtask

    initial begin : stimulus
        exp_t e;
        int   r;
        bus.btn_a_n = 1'b1;
        bus.btn_b_n = 1'b1;
        step(3);
        rst = 1'b0;
        step(3);

        // Single clean A press, held 20 cycles: a 0->1, b stays 0.
        press(1'b1, 1'b0, 20);
        check_ops("a_press_1");

        // Three more A presses: 2, 3, then wrap to 0.
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        check_ops("a_wrap");

        // Build a=2, b=3.
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        press(1'b0, 1'b1, 8);
        press(1'b0, 1'b1, 8);
        check_ops("a2_b3");

        // Simultaneous press clears both; repeat with both already zero.
        press(1'b1, 1'b1, 10);
        check_ops("both_clear");
        press(1'b1, 1'b1, 10);
        check_ops("both_clear_zero");

        // B bouncing every 2 cycles for 30 cycles must not register.
        for (int i = 0; i < 15; i++) begin
            bus.btn_b_n = ~bus.btn_b_n;
            step(2);
        end
        bus.btn_b_n = 1'b1;
        step(12);
        check_ops("bounce_b");

        // A held 100 cycles gives exactly one increment.
        press(1'b1, 1'b0, 100);
        check_ops("a_long_hold");

        // Reset mid-debounce with A held through reset release.
        bus.btn_a_n = 1'b0;
        step(4);
        rst = 1'b1;
        a_m = '0;
        b_m = '0;
        step(1);
        rst = 1'b0;
        r   = cyc;
        a_m = W'(1);
        e.a   = a_m;
        e.b   = b_m;
        e.cyc = r + LAT;
        exp_q.push_back(e);
        step(20);
        bus.btn_a_n = 1'b1;
        step(12);
        check_ops("reset_mid_debounce");

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected updates never seen, required 0",
                     exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_operand_entry
`default_nettype wire

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter INPUT_WIDTH, default 2, width of each operand presented to the downstream adder.
REQ-002 Parameter DEBOUNCE_CYCLES, default 270000, consecutive stable samples required to accept a button level change; legal range >= 2.
REQ-003 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_a_n  input  1  raw push-button A, active-low, asynchronous to clk, may bounce.
REQ-006 btn_b_n  input  1  raw push-button B, active-low, asynchronous to clk, may bounce.
REQ-007 a  output  INPUT_WIDTH  registered operand A, drives adder input a.
REQ-008 b  output  INPUT_WIDTH  registered operand B, drives adder input b.
REQ-009 updated  output  1  registered one-cycle strobe, high in the cycle where a or b takes a new value.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each button SHALL hold a debounced stable level (pressed/released) and a counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-012 Counter SHALL increment each cycle the synchronized level differs from the stable level and SHALL clear to 0 on any cycle it matches.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level SHALL flip on that edge and the counter SHALL clear.
REQ-014 A press event SHALL be a one-cycle pulse when the stable level goes released->pressed; release transitions SHALL generate no event.
REQ-015 A clean press held from edge k SHALL produce its press event in cycle k+DEBOUNCE_CYCLES+2 and the operand change at edge k+DEBOUNCE_CYCLES+3.
REQ-016 Press event on A only: a SHALL become a+1 modulo 2^INPUT_WIDTH; b unchanged.
REQ-017 Press event on B only: b SHALL become b+1 modulo 2^INPUT_WIDTH; a unchanged.
REQ-018 Press events on A and B in the same cycle: a and b SHALL both become 0 (clear), not increment.
REQ-019 Wrap-around: a = 2^INPUT_WIDTH-1 plus A press SHALL yield a = 0 with no carry/flag.
REQ-020 updated SHALL assert for exactly one cycle, coincident with the new a/b values, for every increment or clear, including clear when both were already 0.
REQ-021 A button held indefinitely SHALL produce exactly one event; bounce shorter than DEBOUNCE_CYCLES SHALL produce none.

Reset
REQ-022 While rst is high: a = 0, b = 0, updated = 0, synchronizer flops = released (1), stable levels = released, counters = 0.
REQ-023 Reset asserted mid-debounce SHALL discard the pending count; no event SHALL be emitted for it.
REQ-024 A button held through reset deassertion SHALL be treated as a fresh press, producing one event DEBOUNCE_CYCLES+2 cycles after release of rst.

Structure
REQ-025 Shared package/header SHALL hold the default INPUT_WIDTH and the default DEBOUNCE_CYCLES (27 MHz, 10 ms) constants, and nothing block-private.
REQ-026 The synchronizer, debounce counter and press-edge detect SHALL be one sub-module, button_debounce, instantiated twice; operand registers, clear/increment logic and updated SHALL live in operand_entry.

Verification (INPUT_WIDTH=2, DEBOUNCE_CYCLES=4)
REQ-027 Clean A press held 20 cycles after reset -> a: 0->1 at edge 7 after press start, updated high 1 cycle, b stays 0.
REQ-028 Four A presses -> a sequence 1,2,3,0 (wrap), four updated pulses.
REQ-029 B input toggling every 2 cycles for 30 cycles, then released -> no change to b, updated never high.
REQ-030 a=2, b=3, A and B pressed on the same edge -> both events in the same cycle, a=0, b=0, single updated pulse.
REQ-031 A press counting 3 cycles, rst pulsed 1 cycle, button held -> no event before reset; one event 6 cycles after rst falls; a=1.
REQ-032 A held 100 cycles -> exactly one increment and one updated pulse.
